// File: rtl/otter_fetch_unit.sv
// rtl/otter_fetch_unit.sv - OTTER fetch stage: PC, next-PC select, imem issue, instruction queue
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_EN.
module otter_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              DEPTH     = 2,
    parameter int              PC_STEP   = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            REDIRECT,
    input  logic [1:0]      PC_SOURCE,
    input  logic [XLEN-1:0] JALR,
    input  logic [XLEN-1:0] BRANCH,
    input  logic [XLEN-1:0] JAL,
    output logic            MEM_READ1,
    output logic [XLEN-1:0] MEM_ADDR1,
    input  logic [XLEN-1:0] MEM_DOUT1,
    output logic            IR_VALID,
    input  logic            IR_READY,
    output logic [XLEN-1:0] IR_DATA,
    output logic [XLEN-1:0] IR_PC
`ifdef FETCH_MISALIGN_EN
    ,
    output logic            FETCH_MISALIGN,
    output logic [XLEN-1:0] MISALIGN_PC
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [XLEN-1:0] addr_q [DEPTH];
    logic [XLEN-1:0] addr_d [DEPTH];

    logic            redirect;
    logic            push;
    logic            pop;
    logic            issue_ok;
    logic [CW:0]     occ;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;

`ifdef FETCH_MISALIGN_EN
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_pc_q, misalign_pc_d;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign redirect = REDIRECT && (PC_SOURCE != 2'b00);
    assign pop      = IR_VALID && IR_READY;
    // A response is killed by a redirect arriving in the same cycle.
    assign push     = inflight_q && !redirect;

    // Slots already committed (held + in flight), minus the one leaving this cycle.
    assign occ      = (CW + 1)'(count_q) + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    assign issue_ok = !RESET && (occ < (CW + 1)'(DEPTH));

`ifdef FETCH_MISALIGN_EN
    assign MEM_READ1      = issue_ok && !misalign_q;
    assign FETCH_MISALIGN = misalign_q;
    assign MISALIGN_PC    = misalign_pc_q;
`else
    assign MEM_READ1      = issue_ok;
`endif

    assign MEM_ADDR1 = pc_q;
    assign IR_VALID  = (count_q != '0);
    assign IR_DATA   = IR_VALID ? data_q[rd_ptr_q] : '0;
    assign IR_PC     = IR_VALID ? addr_q[rd_ptr_q] : '0;

    always_comb begin
        target_raw = pc_q;
        case (PC_SOURCE)
            2'd1:    target_raw = JALR;
            2'd2:    target_raw = BRANCH;
            2'd3:    target_raw = JAL;
            default: target_raw = pc_q;
        endcase
        target = target_raw & ~XLEN'(3);
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = MEM_READ1;
        inflight_pc_d = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        data_d        = data_q;
        addr_d        = addr_q;

        if (MEM_READ1) begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end
        if (push) begin
            data_d[wr_ptr_q] = MEM_DOUT1;
            addr_d[wr_ptr_q] = inflight_pc_q;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        // Redirect flushes the queue and kills the read issued this cycle.
        if (redirect) begin
            pc_d       = target;
            inflight_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

`ifdef FETCH_MISALIGN_EN
    always_comb begin
        misalign_d    = misalign_q;
        misalign_pc_d = misalign_pc_q;
        if (redirect) begin
            misalign_d = (target_raw[1:0] != 2'b00);
            if (target_raw[1:0] != 2'b00) begin
                misalign_pc_d = target_raw;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            misalign_q    <= 1'b0;
            misalign_pc_q <= '0;
        end else begin
            misalign_q    <= misalign_d;
            misalign_pc_q <= misalign_pc_d;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q          <= RESET_VEC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            data_q        <= data_d;
            addr_q        <= addr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            assert (!(push && !pop && (count_q == CW'(DEPTH))));
        end
    end

endmodule

// File: tb/tb_otter_fetch_unit.sv
// tb/tb_otter_fetch_unit.sv - directed + random bench for otter_fetch_unit with stream scoreboard
// Exercises FETCH_MISALIGN_EN paths when that macro is defined.
module tb_otter_fetch_unit;

    localparam logic [31:0] K    = 32'hA5A5_0000;
    localparam logic [31:0] RVEC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [1:0]  pc_source = 2'd0;
    logic [31:0] jalr = '0;
    logic [31:0] branch = '0;
    logic [31:0] jal = '0;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
`ifdef FETCH_MISALIGN_EN
    logic        fetch_misalign;
    logic [31:0] misalign_pc;
`endif

    int          checks = 0;
    int          errors = 0;
    int          accepts = 0;
    int          blank = 0;
    int          acc_before = 0;
    bit          rst_seen = 1'b0;
    logic [31:0] exp_pc = RVEC;
    logic [31:0] fetch_pc = RVEC;

    always #5 clk = ~clk;

    // Synchronous instruction memory: word at address A reads as A ^ K one cycle later.
    always @(posedge clk) mem_dout <= mem_read ? (mem_addr ^ K) : 32'hDEAD_BEEF;

    otter_fetch_unit dut (
        .CLK       (clk),
        .RESET     (rst),
        .REDIRECT  (redirect),
        .PC_SOURCE (pc_source),
        .JALR      (jalr),
        .BRANCH    (branch),
        .JAL       (jal),
        .MEM_READ1 (mem_read),
        .MEM_ADDR1 (mem_addr),
        .MEM_DOUT1 (mem_dout),
        .IR_VALID  (ir_valid),
        .IR_READY  (ir_ready),
        .IR_DATA   (ir_data),
        .IR_PC     (ir_pc)
`ifdef FETCH_MISALIGN_EN
        ,
        .FETCH_MISALIGN (fetch_misalign),
        .MISALIGN_PC    (misalign_pc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: the accepted stream is target, target+4, ... from the latest
    // reset/redirect; the fetch address follows the same rule on each issued read.
    task automatic step();
        logic [31:0] t;
        if (rst) begin
            if (rst_seen) begin
                chk("rst_read", 32'(mem_read), 32'd0);
                chk("rst_valid", 32'(ir_valid), 32'd0);
                chk("rst_data", ir_data, 32'd0);
                chk("rst_pc", ir_pc, 32'd0);
                chk("rst_addr", mem_addr, RVEC);
            end
            rst_seen = 1'b1;
            exp_pc   = RVEC;
            fetch_pc = RVEC;
            blank    = 2;
        end else begin
            rst_seen = 1'b0;
            if (blank > 0) begin
                chk("blank_valid", 32'(ir_valid), 32'd0);
                blank--;
            end
            if (mem_read) chk("fetch_addr", mem_addr, fetch_pc);
            if (ir_valid && ir_ready) begin
                chk("stream_pc", ir_pc, exp_pc);
                chk("stream_data", ir_data, exp_pc ^ K);
                exp_pc = exp_pc + 32'd4;
                accepts++;
            end
            if (redirect && pc_source != 2'd0) begin
                t = (pc_source == 2'd1) ? jalr : (pc_source == 2'd2) ? branch : jal;
                t = t & ~32'h3;
                exp_pc   = t;
                fetch_pc = t;
                blank    = 2;
            end else if (mem_read) begin
                fetch_pc = fetch_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        #1;
        step();
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        ir_ready = 1'b0;
        redirect = 1'b0;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);

        // Reset release with decode always ready: first instruction in C2, then one per cycle.
        do_reset(3);
        ir_ready = 1'b1;
        #1;
        chk("c0_read", 32'(mem_read), 32'd1);
        chk("c0_addr", mem_addr, RVEC);
        step();
        cyc();
        #1;
        chk("c2_valid", 32'(ir_valid), 32'd1);
        chk("c2_pc", ir_pc, RVEC);
        step();
        repeat (8) begin
            #1;
            chk("stream_valid", 32'(ir_valid), 32'd1);
            step();
        end

        // JAL redirect mid-stream.
        redirect = 1'b1; pc_source = 2'd3; jal = 32'h100;
        cyc();
        redirect = 1'b0; pc_source = 2'd0;
        cyc();
        cyc();
        #1;
        chk("jal_valid", 32'(ir_valid), 32'd1);
        chk("jal_pc0", ir_pc, 32'h100);
        step();
        #1;
        chk("jal_pc1", ir_pc, 32'h104);
        step();

        // Back-to-back redirects: the later JALR wins.
        redirect = 1'b1; pc_source = 2'd2; branch = 32'h300;
        cyc();
        pc_source = 2'd1; jalr = 32'h200;
        cyc();
        redirect = 1'b0; pc_source = 2'd0;
        cyc();
        cyc();
        #1;
        chk("b2b_valid", 32'(ir_valid), 32'd1);
        chk("b2b_pc", ir_pc, 32'h200);
        step();

        // REDIRECT with PC_SOURCE=0 leaves the stream running.
        cyc();
        redirect = 1'b1; pc_source = 2'd0; jal = 32'h900;
        #1;
        chk("src0_valid", 32'(ir_valid), 32'd1);
        step();
        redirect = 1'b0;
        #1;
        chk("src0_after", 32'(ir_valid), 32'd1);
        step();

        // Reset pulse with a response in flight.
        rst = 1'b1; ir_ready = 1'b0;
        cyc();
        rst = 1'b0; ir_ready = 1'b1;
        cyc();
        cyc();
        #1;
        chk("rst_c2_valid", 32'(ir_valid), 32'd1);
        chk("rst_c2_pc", ir_pc, RVEC);
        step();

        // Stall with a full queue, then drain in order.
        do_reset(2);
        cyc();
        cyc();
        repeat (10) begin
            #1;
            chk("stall_valid", 32'(ir_valid), 32'd1);
            chk("stall_pc", ir_pc, RVEC);
            chk("stall_data", ir_data, RVEC ^ K);
            chk("stall_read", 32'(mem_read), 32'd0);
            step();
        end
        ir_ready = 1'b1;
        acc_before = accepts;
        repeat (6) begin
            #1;
            chk("drain_valid", 32'(ir_valid), 32'd1);
            step();
        end
        chk("drain_count", 32'(accepts - acc_before), 32'd6);

        // Sequential PC wrap past the top of the address space.
        redirect = 1'b1; pc_source = 2'd3; jal = 32'hFFFF_FFF8;
        cyc();
        redirect = 1'b0; pc_source = 2'd0;
        cyc();
        cyc();
        #1;
        chk("wrap_pc0", ir_pc, 32'hFFFF_FFF8);
        step();
        #1;
        chk("wrap_pc1", ir_pc, 32'hFFFF_FFFC);
        step();
        #1;
        chk("wrap_pc2", ir_pc, 32'h0000_0000);
        step();

        // Misaligned redirect target.
        redirect = 1'b1; pc_source = 2'd1; jalr = 32'h102;
        cyc();
        redirect = 1'b0; pc_source = 2'd0;
`ifdef FETCH_MISALIGN_EN
        repeat (4) begin
            #1;
            chk("mis_flag", 32'(fetch_misalign), 32'd1);
            chk("mis_pc", misalign_pc, 32'h102);
            chk("mis_read", 32'(mem_read), 32'd0);
            chk("mis_valid", 32'(ir_valid), 32'd0);
            step();
        end
        redirect = 1'b1; pc_source = 2'd3; jal = 32'h40;
        cyc();
        redirect = 1'b0; pc_source = 2'd0;
        #1;
        chk("mis_clear", 32'(fetch_misalign), 32'd0);
        step();
        cyc();
        #1;
        chk("mis_resume_pc", ir_pc, 32'h40);
        step();
`else
        cyc();
        cyc();
        #1;
        chk("align_valid", 32'(ir_valid), 32'd1);
        chk("align_pc", ir_pc, 32'h100);
        step();
`endif

        // Random traffic: backpressure, redirects of every source, occasional resets.
        acc_before = accepts;
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            ir_ready  = !rst && ($urandom_range(0, 3) != 0);
            redirect  = ($urandom_range(0, 11) == 0);
            pc_source = 2'($urandom_range(0, 3));
            jalr      = $urandom & ~32'h3;
            branch    = $urandom & ~32'h3;
            jal       = $urandom & ~32'h3;
            cyc();
        end
        rst = 1'b0; redirect = 1'b0; pc_source = 2'd0;
        chk("random_progress", 32'((accepts - acc_before) > 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/otter_fetch_unit.md
Name: otter_fetch_unit

Overview:
- Parametrised instruction-fetch stage for the OTTER core; successor to the single-register PC/mux/memory fetch path.
- Owns the PC, selects the next PC from sequential/JALR/BRANCH/JAL sources and issues reads to the 1-cycle-latency synchronous instruction memory port.
- Buffers returned instructions in a DEPTH-entry queue with a valid/ready handshake to decode.
- Redirects flush all buffered and in-flight fetches.

Parameters:
- XLEN, 32, width of PC, targets and instruction word.
- RESET_VEC, 32'h0000_0000, PC loaded on reset; XLEN bits.
- DEPTH, 2, instruction queue entries; legal values 1..16; DEPTH>=2 gives 1 instr/cycle throughput.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REDIRECT  in  1  take a control-flow target this cycle.
- PC_SOURCE  in  2  redirect source: 1=JALR, 2=BRANCH, 3=JAL; 0 with REDIRECT=1 is ignored (treated as no redirect).
- JALR  in  XLEN  JALR target.
- BRANCH  in  XLEN  branch target.
- JAL  in  XLEN  JAL target.
- MEM_READ1  out  1  instruction-memory read strobe.
- MEM_ADDR1  out  XLEN  instruction-memory address (equals current PC).
- MEM_DOUT1  in  XLEN  read data, valid in the cycle after MEM_READ1.
- IR_VALID  out  1  queue head holds a valid instruction.
- IR_READY  in  1  decode accepts the head this cycle.
- IR_DATA  out  XLEN  head instruction.
- IR_PC  out  XLEN  PC of head instruction.

Behaviour:
- Reset (RESET=1 at an edge): PC<=RESET_VEC, queue empty, in-flight flag cleared. Outputs: IR_VALID=0, MEM_READ1=0, MEM_ADDR1=RESET_VEC, IR_DATA/IR_PC=0. RESET mid-operation discards everything, including a response due next cycle.
- Cycle C0 is the first cycle with RESET=0. In C0, MEM_READ1=1 and MEM_ADDR1=RESET_VEC. Data is captured into the queue at the end of C1. IR_VALID=1 in C2.
- Issue rule: MEM_READ1=1 when RESET=0 and (occupancy + inflight - pop) < DEPTH, where pop = IR_VALID & IR_READY. On issue, PC <= PC + PC_STEP, modulo 2^XLEN; wraps silently.
- Response: when the in-flight flag is set and not killed, {PC_issued, MEM_DOUT1} is pushed at the edge ending the response cycle. Push and pop in the same cycle are legal; occupancy is unchanged.
- Queue is FIFO ordered. IR_DATA and IR_PC are held stable while IR_VALID=1 and IR_READY=0. Overflow cannot occur by construction; assert in sim.
- Redirect in cycle R (REDIRECT=1, PC_SOURCE!=0):
  - PC <= selected target at end of R.
  - Queue flushed at end of R.
  - Any response arriving in R, and the read issued in R, are killed and never pushed.
  - A handshake completing in R is honoured: decode owns that instruction.
  - IR_VALID=0 in R+1 and R+2; target is fetched in R+1 and presented no earlier than R+3.
- Redirect overrides the issue increment. RESET overrides redirect.
- Back-to-back redirects: the last one wins; each kills all older fetches.
- Stall: IR_READY=0 with a full queue stops issue; PC holds and MEM_READ1=0.

Optional Feature:
- Macro FETCH_MISALIGN_EN.
- Defined:
  - Adds output FETCH_MISALIGN (1 bit) and MISALIGN_PC (XLEN).
  - A redirect target with [1:0]!=2'b00 loads MISALIGN_PC with the target and sets FETCH_MISALIGN=1 from R+1.
  - While set, issue is suppressed.
  - Cleared by RESET or the next aligned redirect.
  - Reset value 0 for both outputs.
- Undefined: target[1:0] is forced to 2'b00 on load; no extra ports.

Test Plan:
- Reset release, IR_READY=1, memory returns addr^32'hA5A5_0000 -> IR_VALID first in C2 with IR_PC=0. Then IR_PC 0,4,8,... on consecutive cycles, one per cycle.
- IR_READY=0 for 10 cycles (DEPTH=2) -> queue holds PC 0,4; MEM_READ1=0 after fill; IR_DATA stable. On release, order 0,4,8 with no gaps or duplicates.
- Redirect PC_SOURCE=3, JAL=32'h100 mid-stream -> IR_VALID low for 2 cycles, then IR_PC=32'h100, 32'h104. No stale PC appears after the redirect.
- Redirect PC_SOURCE=2 then PC_SOURCE=1 (JALR=32'h200) on consecutive cycles -> first IR_PC after both is 32'h200.
- RESET pulsed while a response is in flight -> no push; restart at RESET_VEC with C2 timing. REDIRECT with PC_SOURCE=0 -> no effect.
- PC=32'hFFFF_FFFC sequential issue -> next IR_PC=32'h0. With FETCH_MISALIGN_EN, JALR=32'h102 -> FETCH_MISALIGN=1, MISALIGN_PC=32'h102, MEM_READ1=0.
